// File: rtl/periwinkle_core.sv
// periwinkle_core: move-only CPU core; each instruction moves a literal or register into a GPR or SPR.
// Define PERIWINKLE_CYCLE_COUNTER_EN to back SPR 10 with a loadable free-running cycle counter.
module periwinkle_core #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_GPRS = 32,
    parameter int INSTR_W  = DATA_W + 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [DATA_W-1:0]  o_pc,
    output logic               o_halted
);
    localparam logic [4:0] SPR_PC   = 5'd0;
    localparam logic [4:0] SPR_SIZ  = 5'd8;
    localparam logic [4:0] SPR_SINZ = 5'd9;
    localparam logic [4:0] SPR_HALT = 5'd11;

    localparam logic [DATA_W-1:0] ZERO_C = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_C  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] TWO_C  = {{(DATA_W-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic               req_r, req_s;
    logic               halted_r, halted_s;
    logic [DATA_W-1:0]  pc_r, pc_s, next_pc_s;
    logic [INSTR_W-1:0] ir_r, ir_s;
    logic [DATA_W-1:0]  gpr_r [NUM_GPRS];

    logic               xfer_s;
    logic [DATA_W-1:0]  src_s;
    logic [5:0]         dst_s;
    logic [DATA_W-1:0]  src_val_s;
    logic               exec_s, gpr_we_s, halt_wr_s;
    logic               reserved_unused_s;

    function automatic logic gpr_valid(input logic [4:0] idx);
        return (32'(idx) < 32'(NUM_GPRS));
    endfunction

    assign xfer_s            = ir_r[INSTR_W-1];
    assign reserved_unused_s = ir_r[INSTR_W-2];
    assign src_s             = ir_r[DATA_W+5:6];
    assign dst_s             = ir_r[5:0];
    assign exec_s            = (state_r == ST_EXEC);
    assign gpr_we_s          = exec_s && dst_s[5] && gpr_valid(dst_s[4:0]);
    assign halt_wr_s         = exec_s && !dst_s[5] && (dst_s[4:0] == SPR_HALT);

`ifdef PERIWINKLE_CYCLE_COUNTER_EN
    localparam logic [4:0] SPR_CYC = 5'd10;
    logic [DATA_W-1:0] cyc_r;
    logic              cyc_we_s;
    assign cyc_we_s = exec_s && !dst_s[5] && (dst_s[4:0] == SPR_CYC);

    // Cycle counter: a load wins over the increment; it stops once halted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_r <= ZERO_C;
        end else if (cyc_we_s) begin
            cyc_r <= src_val_s;
        end else if (!halted_r) begin
            cyc_r <= cyc_r + ONE_C;
        end
    end
`endif

    // Source operand: literal, GPR (0 when unimplemented) or SPR readback.
    always_comb begin
        src_val_s = ZERO_C;
        if (!xfer_s) begin
            src_val_s = src_s;
        end else if (src_s[5]) begin
            if (gpr_valid(src_s[4:0])) begin
                src_val_s = gpr_r[src_s[4:0]];
            end else begin
                src_val_s = ZERO_C;
            end
        end else begin
            case (src_s[4:0])
                SPR_PC:  src_val_s = pc_r;
`ifdef PERIWINKLE_CYCLE_COUNTER_EN
                SPR_CYC: src_val_s = cyc_r;
`endif
                default: src_val_s = ZERO_C;
            endcase
        end
    end

    // Next PC: jumps and conditional skips are side effects of SPR writes.
    always_comb begin
        next_pc_s = pc_r + ONE_C;
        if (!dst_s[5]) begin
            case (dst_s[4:0])
                SPR_PC:   next_pc_s = src_val_s;
                SPR_SIZ:  next_pc_s = (src_val_s == ZERO_C) ? pc_r + TWO_C : pc_r + ONE_C;
                SPR_SINZ: next_pc_s = (src_val_s != ZERO_C) ? pc_r + TWO_C : pc_r + ONE_C;
                default:  next_pc_s = pc_r + ONE_C;
            endcase
        end else begin
            next_pc_s = pc_r + ONE_C;
        end
    end

    // Fetch/execute/halt sequencing; req is registered so it is low straight out of reset.
    always_comb begin
        state_s  = state_r;
        req_s    = req_r;
        halted_s = halted_r;
        pc_s     = pc_r;
        ir_s     = ir_r;
        case (state_r)
            ST_FETCH: begin
                if (req_r && i_imem_ack) begin
                    ir_s    = i_imem_data;
                    req_s   = 1'b0;
                    state_s = ST_EXEC;
                end else begin
                    req_s   = 1'b1;
                    state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                pc_s = next_pc_s;
                if (halt_wr_s) begin
                    state_s  = ST_HALT;
                    req_s    = 1'b0;
                    halted_s = 1'b1;
                end else begin
                    state_s  = ST_FETCH;
                    req_s    = 1'b1;
                end
            end
            ST_HALT: begin
                req_s    = 1'b0;
                halted_s = 1'b1;
            end
            default: begin
                state_s  = ST_FETCH;
                req_s    = 1'b0;
                halted_s = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_FETCH;
            req_r    <= 1'b0;
            halted_r <= 1'b0;
            pc_r     <= ZERO_C;
            ir_r     <= {INSTR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            req_r    <= req_s;
            halted_r <= halted_s;
            pc_r     <= pc_s;
            ir_r     <= ir_s;
        end
    end

    // GPR file; a self-move reads the old value, so it is a no-op.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_GPRS; i++) begin
                gpr_r[i] <= ZERO_C;
            end
        end else if (gpr_we_s) begin
            gpr_r[dst_s[4:0]] <= src_val_s;
        end
    end

    assign o_imem_req  = req_r;
    assign o_imem_addr = pc_r[ADDR_W-1:0];
    assign o_pc        = pc_r;
    assign o_halted    = halted_r;
endmodule

// File: tb/tb_periwinkle_core.sv
// Self-checking bench for periwinkle_core: directed tables, hand sequences and a random
// program run against an instruction-level reference interpreter.
module tb_periwinkle_core;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NG = 24;
    localparam int IW = DW + 8;

    localparam logic [5:0] S_PC   = 6'd0;
    localparam logic [5:0] S_SIZ  = 6'd8;
    localparam logic [5:0] S_SINZ = 6'd9;
    localparam logic [5:0] S_CYC  = 6'd10;
    localparam logic [5:0] S_HALT = 6'd11;
    localparam logic [5:0] S_NULL = 6'd12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_data = '0;
    logic [DW-1:0] pc;
    logic          halted;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit stalled = 1'b0;

    logic [IW-1:0] mem [256];
    logic [DW-1:0] m_gpr [32];
    logic [DW-1:0] m_pc;

    typedef struct {
        logic [DW-1:0] start;
        logic [IW-1:0] ins;
        logic [DW-1:0] exp_pc;
    } tvec_t;
    tvec_t tv [12];

    logic [DW-1:0] t_a, t_p, exp_cnt;
    int            t_c;

    periwinkle_core #(.DATA_W(DW), .ADDR_W(AW), .NUM_GPRS(NG)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_imem_req  (imem_req),
        .o_imem_addr (imem_addr),
        .i_imem_ack  (imem_ack),
        .i_imem_data (imem_data),
        .o_pc        (pc),
        .o_halted    (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IW-1:0] lit(input logic [DW-1:0] v, input logic [5:0] d);
        return {1'b0, 1'b0, v, d};
    endfunction

    function automatic logic [IW-1:0] mov(input logic [5:0] s, input logic [5:0] d);
        return {1'b1, 1'b0, {(DW-6){1'b0}}, s, d};
    endfunction

    function automatic logic [5:0] g(input int n);
        return {1'b1, n[4:0]};
    endfunction

    function automatic logic [IW-1:0] rnd_instr();
        logic [DW-1:0] src;
        logic [5:0]    dst;
        logic          tr;
        src = $urandom;
        tr  = 1'($urandom_range(0, 1));
        if (tr) begin
            if (!src[5] && src[4:0] == 5'd10) src[4:0] = 5'd0;
        end else if ($urandom_range(0, 3) == 0) begin
            src = '0;
        end
        case ($urandom_range(0, 5))
            0, 1, 2: dst = {1'b1, 5'($urandom_range(0, 31))};
            3:       dst = S_PC;
            4:       dst = ($urandom_range(0, 1) != 0) ? S_SIZ : S_SINZ;
            default: begin
                dst = {1'b0, 5'($urandom_range(0, 31))};
                if (dst == S_CYC || dst == S_HALT) dst = S_NULL;
            end
        endcase
        return {tr, 1'($urandom_range(0, 1)), src, dst};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = lit(32'd0, S_NULL);
    endtask

    // Reset, then offer a jump instruction while req is still low: it must be ignored.
    task automatic do_reset();
        imem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack  = 1'b1;
        imem_data = lit(32'h99, S_PC);
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    // Wait for a request, hold it for dly cycles, then ack with the memory word.
    task automatic serve_fetch(input int dly, output logic [DW-1:0] a, output logic [DW-1:0] p,
                               output int c);
        int t;
        t = 0;
        a = '0;
        p = '0;
        c = 0;
        while (imem_req !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
        if (imem_req !== 1'b1) begin
            stalled = 1'b1;
            return;
        end
        a = {{(DW-AW){1'b0}}, imem_addr};
        p = pc;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("hold_req", {31'd0, imem_req}, 32'd1);
            chk("hold_addr", {{(DW-AW){1'b0}}, imem_addr}, a);
        end
        imem_ack  = 1'b1;
        imem_data = mem[a[AW-1:0]];
        c = cyc;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = IW'({$urandom, $urandom});
    endtask

    // Reference interpreter: one architectural instruction at a time.
    task automatic model_exec(input logic [IW-1:0] ins, output bit halt);
        logic [DW-1:0] src, v, npc;
        logic [5:0]    d;
        src  = ins[DW+5:6];
        d    = ins[5:0];
        halt = 1'b0;
        if (!ins[IW-1])                v = src;
        else if (src[5])               v = (int'(src[4:0]) < NG) ? m_gpr[src[4:0]] : '0;
        else if (src[4:0] == 5'd0)     v = m_pc;
        else                           v = '0;
        npc = m_pc + 32'd1;
        if (d[5]) begin
            if (int'(d[4:0]) < NG) m_gpr[d[4:0]] = v;
        end else if (d[4:0] == 5'd0)                 npc = v;
        else if (d[4:0] == 5'd8 && v == '0)          npc = m_pc + 32'd2;
        else if (d[4:0] == 5'd9 && v != '0)          npc = m_pc + 32'd2;
        else if (d[4:0] == 5'd11)                    halt = 1'b1;
        m_pc = npc;
    endtask

    task automatic run_prog(input string tag, input int n, input int dly);
        logic [DW-1:0] a, p;
        int            c, prev_c, d;
        bit            h;
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_pc    = '0;
        stalled = 1'b0;
        prev_c  = -1;
        for (int k = 0; k < n && !stalled; k++) begin
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            serve_fetch(d, a, p, c);
            if (stalled) break;
            chk({tag, "_addr"}, a, {{(DW-AW){1'b0}}, m_pc[AW-1:0]});
            chk({tag, "_pc"}, p, m_pc);
            if (dly >= 0 && prev_c >= 0) chk({tag, "_cycles"}, DW'(c - prev_c), DW'(2 + dly));
            prev_c = c;
            model_exec(mem[m_pc[AW-1:0]], h);
            if (h) begin
                @(negedge clk);
                chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
                for (int j = 0; j < 4; j++) begin
                    imem_ack = 1'b1;
                    @(negedge clk);
                    chk({tag, "_halt_req"}, {31'd0, imem_req}, 32'd0);
                    chk({tag, "_halt_pc"}, pc, m_pc);
                end
                imem_ack = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{32'd4,          lit(32'd0, S_SIZ),           32'd6};
        tv[1]  = '{32'd4,          lit(32'd1, S_SIZ),           32'd5};
        tv[2]  = '{32'd4,          lit(32'd1, S_SINZ),          32'd6};
        tv[3]  = '{32'd4,          lit(32'd0, S_SINZ),          32'd5};
        tv[4]  = '{32'd3,          lit(32'h20, S_PC),           32'h20};
        tv[5]  = '{32'h20,         mov(S_PC, S_SINZ),           32'h22};
        tv[6]  = '{32'd5,          lit(32'd7, S_NULL),          32'd6};
        tv[7]  = '{32'hFF,         lit(32'd5, g(1)),            32'h100};
        tv[8]  = '{32'hFFFF_FFFF,  lit(32'd5, g(2)),            32'd0};
        tv[9]  = '{32'd7,          mov(6'd13, S_SIZ),           32'd9};
        tv[10] = '{32'h1FE,        mov(S_PC, S_PC),             32'h1FE};
        tv[11] = '{32'd6,          lit(32'hFFFF_FFFF, S_SIZ),   32'd7};

        // Values held during reset.
        #12;
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_pc", pc, 32'd0);

        // Zero-wait program: moves, dropped write, skips, self-move, halt.
        clear_mem();
        mem[8'h00] = lit(32'h1234_5678, g(5));
        mem[8'h01] = mov(g(5), g(7));
        mem[8'h02] = mov(g(7), S_PC);
        mem[8'h78] = lit(32'h55, g(30));
        mem[8'h79] = mov(g(30), S_SIZ);
        mem[8'h7B] = mov(g(7), g(7));
        mem[8'h7C] = mov(g(7), S_SINZ);
        mem[8'h7E] = lit(32'd0, S_HALT);
        do_reset();
        run_prog("zw", 12, 0);

        // Same program with three wait cycles per fetch.
        do_reset();
        run_prog("ws", 12, 3);

        // Single control-flow instructions from a chosen PC.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            clear_mem();
            mem[0] = lit(tv[i].start, S_PC);
            mem[tv[i].start[AW-1:0]] = tv[i].ins;
            serve_fetch(0, t_a, t_p, t_c);
            chk("tv_first_addr", t_a, 32'd0);
            serve_fetch(0, t_a, t_p, t_c);
            chk("tv_start_pc", t_p, tv[i].start);
            serve_fetch(0, t_a, t_p, t_c);
            chk("tv_next_pc", t_p, tv[i].exp_pc);
            chk("tv_next_addr", t_a, {{(DW-AW){1'b0}}, tv[i].exp_pc[AW-1:0]});
        end

        // Cycle counter load, read two instructions later, exposed through a jump.
`ifdef PERIWINKLE_CYCLE_COUNTER_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        do_reset();
        clear_mem();
        mem[0] = lit(32'hFFFF_FFFE, S_CYC);
        mem[1] = lit(32'd0, S_NULL);
        mem[2] = mov(S_CYC, g(2));
        mem[3] = mov(g(2), S_PC);
        for (int i = 0; i < 4; i++) serve_fetch(0, t_a, t_p, t_c);
        serve_fetch(0, t_a, t_p, t_c);
        chk("cnt_pc", t_p, exp_cnt);
        chk("cnt_addr", t_a, {{(DW-AW){1'b0}}, exp_cnt[AW-1:0]});

        // Reset asserted while a fetch is pending.
        do_reset();
        clear_mem();
        mem[0] = lit(32'hAB, g(5));
        serve_fetch(0, t_a, t_p, t_c);
        @(negedge clk);
        chk("midfetch_req_before", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midfetch_req_async", {31'd0, imem_req}, 32'd0);
        chk("midfetch_pc", pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem[0] = mov(g(5), S_PC);
        run_prog("rst", 3, 0);

        // Random programs with random wait states.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = rnd_instr();
            do_reset();
            run_prog("rnd", 250, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
